alu16bit_sub_seq: RTL and testbench



---
 rtl/alu16_pkg.sv | 18 +
 rtl/sub_digit.sv | 16 +
 rtl/alu16bit_sub_seq.sv | 145 ++++++++++++++
 tb/tb_alu16bit_sub_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// Shared types and helpers for the 16-bit ALU datapaths.
// The overflow helper is shared by the serial and combinational subtract paths.
package alu16_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of x - y, judged from the operand and result sign bits.
    function automatic logic sub_overflow(input logic x_msb, input logic y_msb, input logic z_msb);
        return (x_msb & ~y_msb & ~z_msb) | (~x_msb & y_msb & z_msb);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// One DIGIT_W-bit slice of a ripple subtractor: {bout, d} = xd - yd - bin.
module sub_digit #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] xd,
    input  logic [DIGIT_W-1:0] yd,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    always_comb begin
        {bout, d} = {1'b0, xd} - {1'b0, yd} - {{DIGIT_W{1'b0}}, bin};
    end

endmodule

// File: rtl/alu16bit_sub_seq.sv
// Digit-serial 16-bit subtractor Z = X - Y with start/busy/done handshake.
// Result and flags update together in the final digit cycle and hold until the next done.
module alu16bit_sub_seq
    import alu16_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ALU_W-1:0] X,
    input  logic [ALU_W-1:0] Y,
    output logic [ALU_W-1:0] Z,
    output logic             Sign,
    output logic             Zero,
    output logic             Borrow,
    output logic             Parity,
    output logic             Overflow,
    output logic             busy,
    output logic             done
);

    localparam int N     = ALU_W / DIGIT_W;
    localparam int CNT_W = $clog2(N) + 1;

    if (DIGIT_W != 1 && DIGIT_W != 2 && DIGIT_W != 4 && DIGIT_W != 8 && DIGIT_W != 16) begin : g_bad_digit_w
        $error("alu16bit_sub_seq: DIGIT_W must be 1, 2, 4, 8 or 16");
    end

    state_e             state_q, state_d;
    logic [ALU_W-1:0]   xs_q, xs_d, ys_q, ys_d, zs_q, zs_d, zs_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bin_q, bin_d, x15_q, x15_d, y15_q, y15_d;
    logic [ALU_W-1:0]   z_q, z_d;
    logic               sign_q, sign_d, zero_q, zero_d, borrow_q, borrow_d;
    logic               parity_q, parity_d, ovf_q, ovf_d;
    logic [DIGIT_W-1:0] digit;
    logic               bout;

    sub_digit #(.DIGIT_W(DIGIT_W)) u_sub_digit (
        .xd   (xs_q[DIGIT_W-1:0]),
        .yd   (ys_q[DIGIT_W-1:0]),
        .bin  (bin_q),
        .d    (digit),
        .bout (bout)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        zs_d     = zs_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        x15_d    = x15_q;
        y15_d    = y15_q;
        z_d      = z_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        borrow_d = borrow_q;
        parity_d = parity_q;
        ovf_d    = ovf_q;
        // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
        zs_next  = (zs_q >> DIGIT_W) | (ALU_W'(digit) << (ALU_W - DIGIT_W));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    xs_d    = X;
                    ys_d    = Y;
                    x15_d   = X[ALU_W-1];
                    y15_d   = Y[ALU_W-1];
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                xs_d  = xs_q >> DIGIT_W;
                ys_d  = ys_q >> DIGIT_W;
                zs_d  = zs_next;
                bin_d = bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d  = DONE;
                    z_d      = zs_next;
                    sign_d   = zs_next[ALU_W-1];
                    zero_d   = (zs_next == '0);
                    borrow_d = bout;
                    parity_d = ~^zs_next;
                    ovf_d    = sub_overflow(x15_q, y15_q, zs_next[ALU_W-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            xs_q     <= '0;
            ys_q     <= '0;
            zs_q     <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            x15_q    <= 1'b0;
            y15_q    <= 1'b0;
            z_q      <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            borrow_q <= 1'b0;
            parity_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            zs_q     <= zs_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            x15_q    <= x15_d;
            y15_q    <= y15_d;
            z_q      <= z_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            borrow_q <= borrow_d;
            parity_q <= parity_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Z        = z_q;
    assign Sign     = sign_q;
    assign Zero     = zero_q;
    assign Borrow   = borrow_q;
    assign Parity   = parity_q;
    assign Overflow = ovf_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_alu16bit_sub_seq.sv
// Directed bench for alu16bit_sub_seq: one instance with DIGIT_W=1, one with DIGIT_W=4.
module tb_alu16bit_sub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4;
    logic [15:0] x1, y1, x4, y4;
    logic [15:0] z1, z4;
    logic        sign1, zero1, borrow1, parity1, ovf1, busy1, done1;
    logic        sign4, zero4, borrow4, parity4, ovf4, busy4, done4;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    alu16bit_sub_seq #(.DIGIT_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .X(x1), .Y(y1), .Z(z1),
        .Sign(sign1), .Zero(zero1), .Borrow(borrow1), .Parity(parity1),
        .Overflow(ovf1), .busy(busy1), .done(done1)
    );

    alu16bit_sub_seq #(.DIGIT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .X(x4), .Y(y4), .Z(z4),
        .Sign(sign4), .Zero(zero4), .Borrow(borrow4), .Parity(parity4),
        .Overflow(ovf4), .busy(busy4), .done(done4)
    );

    typedef struct packed {
        logic [15:0] z;
        logic        sign, zero, borrow, parity, ovf, busy, done;
    } obs_t;

    function automatic obs_t get_obs(input int sel);
        if (sel == 0) return {z1, sign1, zero1, borrow1, parity1, ovf1, busy1, done1};
        return {z4, sign4, zero4, borrow4, parity4, ovf4, busy4, done4};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [15:0] x, input logic [15:0] y);
        if (sel == 0) begin start1 = s; x1 = x; y1 = y; end
        else          begin start4 = s; x4 = x; y4 = y; end
    endtask

    // Called on a falling edge; the next rising edge accepts the operation.
    task automatic op_begin(input int sel, input logic [15:0] x, input logic [15:0] y);
        drive(sel, 1'b1, x, y);
    endtask

    // Counts edges from the accepting edge until done. Operands are scrambled after
    // acceptance; with inject, a second start is pulsed while busy. With chk_hold, Z
    // must stay at hold_z in every cycle before done.
    task automatic op_wait(input int sel, input bit inject, input bit chk_hold,
                           input logic [15:0] hold_z, output int lat, output int busy_cnt);
        obs_t o;
        lat = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            o = get_obs(sel);
            if (o.done) return;
            if (o.busy) busy_cnt++;
            if (chk_hold) check("z_hold", o.z, hold_z);
            drive(sel, inject && lat == 1, 16'h1111, 16'h0001);
            if (lat == 1 && !inject) drive(sel, 1'b0, 16'hDEAD, 16'hBEEF);
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input int sel, input string tag, input logic [15:0] ez,
                                input logic es, input logic ezr, input logic eb,
                                input logic ep, input logic eo);
        obs_t o = get_obs(sel);
        check({tag, ".Z"}, o.z, ez);
        check({tag, ".Sign"}, o.sign, es);
        check({tag, ".Zero"}, o.zero, ezr);
        check({tag, ".Borrow"}, o.borrow, eb);
        check({tag, ".Parity"}, o.parity, ep);
        check({tag, ".Overflow"}, o.ovf, eo);
    endtask

    task automatic run_dw1(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] ez, input logic es, input logic ezr,
                           input logic eb, input logic ep, input logic eo);
        int lat, bc;
        op_begin(0, x, y);
        op_wait(0, 1'b0, 1'b0, 16'h0, lat, bc);
        check({tag, ".latency"}, lat, 17);
        check({tag, ".busy_cycles"}, bc, 16);
        check_result(0, tag, ez, es, ezr, eb, ep, eo);
    endtask

    initial begin
        int lat, bc, seen;
        obs_t o;
        rst = 1'b1;
        drive(0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            o = get_obs(s);
            check("reset_state", o, '0);
        end

        // DIGIT_W=1 arithmetic and flags
        run_dw1("sub_5_3",       16'h0005, 16'h0003, 16'h0002, 0, 0, 0, 0, 0);
        run_dw1("sub_3_5",       16'h0003, 16'h0005, 16'hFFFE, 1, 0, 1, 0, 0);
        run_dw1("sub_8000_1",    16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 0, 1);
        run_dw1("sub_7fff_ffff", 16'h7FFF, 16'hFFFF, 16'h8000, 1, 0, 1, 0, 1);
        run_dw1("sub_equal",     16'h1234, 16'h1234, 16'h0000, 0, 1, 0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", done1, 1'b0);

        // Reset in cycle 3 of an operation aborts it
        op_begin(0, 16'hAAAA, 16'h5555);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'h0, 16'h0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        o = get_obs(0);
        check("rst_abort_outputs", o, '0);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (done1) seen++;
        end
        check("rst_no_done", seen, 0);
        run_dw1("after_rst", 16'hAAAA, 16'h5555, 16'h5555, 0, 0, 0, 1, 1);

        // DIGIT_W=4: latency, ignored start while busy, back-to-back in done cycle
        op_begin(1, 16'h00FF, 16'h0100);
        op_wait(1, 1'b1, 1'b0, 16'h0, lat, bc);
        check("dw4.latency", lat, 5);
        check("dw4.busy_cycles", bc, 4);
        check_result(1, "dw4_ignored_start", 16'hFFFF, 1, 0, 1, 1, 0);

        op_begin(1, 16'h1000, 16'h0001);
        op_wait(1, 1'b0, 1'b1, 16'hFFFF, lat, bc);
        check("dw4_b2b.latency", lat, 5);
        check("dw4_b2b.busy_cycles", bc, 4);
        check_result(1, "dw4_b2b", 16'h0FFF, 0, 0, 0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        check("dw4.done_one_cycle", done4, 1'b0);
        check("dw4.idle_busy", busy4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
